// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module   : mips_ctrl_pkg
// Brief    : Opcodes, ALU op codes, trap causes, FSM states and control word
//            shared by the MIPS-lite multi-cycle controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    localparam logic [5:0] c_op_r   = 6'b000000;
    localparam logic [5:0] c_op_ori = 6'b001101;
    localparam logic [5:0] c_op_lw  = 6'b100011;
    localparam logic [5:0] c_op_sw  = 6'b101011;
    localparam logic [5:0] c_op_beq = 6'b000100;
    localparam logic [5:0] c_op_jal = 6'b000011;

    localparam logic [1:0] c_alu_add   = 2'b00;
    localparam logic [1:0] c_alu_sub   = 2'b01;
    localparam logic [1:0] c_alu_or    = 2'b10;
    localparam logic [1:0] c_alu_funct = 2'b11;

    localparam logic [1:0] c_cause_none    = 2'b00;
    localparam logic [1:0] c_cause_illegal = 2'b01;
    localparam logic [1:0] c_cause_imem    = 2'b10;
    localparam logic [1:0] c_cause_dmem    = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_JAL    = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    // Static per-opcode controls; the FSM decides in which state each applies.
    typedef struct packed {
        logic       legal;
        logic       reg_dst;
        logic       alu_src;
        logic       extend_op;
        logic       write_reg_mux;
        logic [1:0] alu_op;
    } ctrl_word_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Module   : multicycle_controller_if
// Brief    : Controller <-> datapath/memory signal bundle with modports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_controller_if #(
    parameter int ALU_OP_W = 2
) ();
    logic [5:0]          op;
    logic                imem_ready;
    logic                dmem_ready;
    logic                imem_req;
    logic                ir_write;
    logic                pc_write;
    logic                pc_write_cond;
    logic                jmp;
    logic                dmem_req;
    logic                mem_write;
    logic                reg_write;
    logic                reg_dst;
    logic                write_reg_mux;
    logic                link;
    logic                alu_src;
    logic                extend_op;
    logic [ALU_OP_W-1:0] alu_op;
    logic                instr_done;
    logic                trap;
    logic [1:0]          trap_cause;

    modport master (
        input  op, imem_ready, dmem_ready,
        output imem_req, ir_write, pc_write, pc_write_cond, jmp, dmem_req,
               mem_write, reg_write, reg_dst, write_reg_mux, link, alu_src,
               extend_op, alu_op, instr_done, trap, trap_cause
    );

    modport slave (
        output op, imem_ready, dmem_ready,
        input  imem_req, ir_write, pc_write, pc_write_cond, jmp, dmem_req,
               mem_write, reg_write, reg_dst, write_reg_mux, link, alu_src,
               extend_op, alu_op, instr_done, trap, trap_cause
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_controller_op_decode.sv
// ============================================================================
// Module   : op_decode
// Brief    : Combinational opcode to static control word mapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module op_decode
    import mips_ctrl_pkg::*;
(
    input  wire logic [5:0] i_op,
    output ctrl_word_t      o_word
);

    always_comb begin
        o_word = '0;
        case (i_op)
            c_op_r: begin
                o_word.legal   = 1'b1;
                o_word.reg_dst = 1'b1;
                o_word.alu_op  = c_alu_funct;
            end
            c_op_ori: begin
                o_word.legal   = 1'b1;
                o_word.alu_src = 1'b1;
                o_word.alu_op  = c_alu_or;
            end
            c_op_lw: begin
                o_word.legal         = 1'b1;
                o_word.alu_src       = 1'b1;
                o_word.extend_op     = 1'b1;
                o_word.write_reg_mux = 1'b1;
                o_word.alu_op        = c_alu_add;
            end
            c_op_sw: begin
                o_word.legal     = 1'b1;
                o_word.alu_src   = 1'b1;
                o_word.extend_op = 1'b1;
                o_word.alu_op    = c_alu_add;
            end
            c_op_beq: begin
                o_word.legal  = 1'b1;
                o_word.alu_op = c_alu_sub;
            end
            c_op_jal: begin
                o_word.legal = 1'b1;
            end
            default: o_word = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Brief    : MIPS-lite multi-cycle control FSM with ready stalls and traps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_OP_W   = 2,
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input  wire logic               clk,
    input  wire logic               rst,
    multicycle_controller_if.master bus
);

    localparam logic                c_timeout_en = (WAIT_LIMIT != 0);
    localparam logic [CNT_W-1:0]    c_wait_limit = CNT_W'(WAIT_LIMIT);

    state_t             r_state;
    state_t             w_state_next;
    logic [5:0]         r_op_q;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   w_wait_inc;
    logic [1:0]         r_trap_cause;
    logic [1:0]         w_trap_cause_next;
    logic [5:0]         w_dec_op;
    logic               w_wait;
    logic               w_limit_hit;
    ctrl_word_t         w_word;

    // DECODE judges the live opcode; later states use the captured copy.
    assign w_dec_op = (r_state == S_DECODE) ? bus.op : r_op_q;

    op_decode u_op_decode (
        .i_op   (w_dec_op),
        .o_word (w_word)
    );

    assign w_wait = ((r_state == S_FETCH) && !bus.imem_ready) ||
                    ((r_state == S_MEM)   && !bus.dmem_ready);
    assign w_wait_inc  = r_wait_cnt + 1'b1;
    assign w_limit_hit = c_timeout_en && w_wait && (w_wait_inc == c_wait_limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_op_q       <= '0;
            r_wait_cnt   <= '0;
            r_trap_cause <= c_cause_none;
        end else begin
            r_state      <= w_state_next;
            r_trap_cause <= w_trap_cause_next;
            if (r_state == S_DECODE) begin
                r_op_q <= bus.op;
            end
            if (w_state_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_wait) begin
                r_wait_cnt <= w_wait_inc;
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_trap_cause_next = r_trap_cause;
        bus.imem_req      = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.jmp           = 1'b0;
        bus.dmem_req      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.write_reg_mux = 1'b0;
        bus.link          = 1'b0;
        bus.alu_src       = 1'b0;
        bus.extend_op     = 1'b0;
        bus.alu_op        = '0;
        bus.instr_done    = 1'b0;
        bus.trap          = 1'b0;
        bus.trap_cause    = c_cause_none;

        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        w_state_next = S_DECODE;
                    end else if (w_limit_hit) begin
                        w_state_next      = S_TRAP;
                        w_trap_cause_next = c_cause_imem;
                    end
                end
                S_DECODE: begin
                    if (!w_word.legal) begin
                        w_state_next      = S_TRAP;
                        w_trap_cause_next = c_cause_illegal;
                    end else if (w_dec_op == c_op_jal) begin
                        w_state_next = S_JAL;
                    end else begin
                        w_state_next = S_EXEC;
                    end
                end
                S_EXEC: begin
                    bus.alu_src   = w_word.alu_src;
                    bus.extend_op = w_word.extend_op;
                    bus.alu_op    = ALU_OP_W'(w_word.alu_op);
                    if (r_op_q == c_op_beq) begin
                        bus.pc_write_cond = 1'b1;
                        bus.instr_done    = 1'b1;
                        w_state_next      = S_FETCH;
                    end else if ((r_op_q == c_op_lw) || (r_op_q == c_op_sw)) begin
                        w_state_next = S_MEM;
                    end else begin
                        w_state_next = S_WB;
                    end
                end
                S_MEM: begin
                    bus.dmem_req  = 1'b1;
                    bus.mem_write = (r_op_q == c_op_sw);
                    if (bus.dmem_ready) begin
                        if (r_op_q == c_op_sw) begin
                            bus.instr_done = 1'b1;
                            w_state_next   = S_FETCH;
                        end else begin
                            w_state_next = S_WB;
                        end
                    end else if (w_limit_hit) begin
                        w_state_next      = S_TRAP;
                        w_trap_cause_next = c_cause_dmem;
                    end
                end
                S_WB: begin
                    bus.reg_write     = 1'b1;
                    bus.instr_done    = 1'b1;
                    bus.reg_dst       = w_word.reg_dst;
                    bus.write_reg_mux = w_word.write_reg_mux;
                    w_state_next      = S_FETCH;
                end
                S_JAL: begin
                    bus.jmp        = 1'b1;
                    bus.pc_write   = 1'b1;
                    bus.reg_write  = 1'b1;
                    bus.link       = 1'b1;
                    bus.instr_done = 1'b1;
                    w_state_next   = S_FETCH;
                end
                S_TRAP: begin
                    bus.trap       = 1'b1;
                    bus.trap_cause = r_trap_cause;
                end
                default: w_state_next = S_FETCH;
            endcase
        end
    end

endmodule

`default_nettype wire
